// File: rtl/gam_mem_scheduler.sv
// gam_mem_scheduler: single-port sequencer/arbiter in front of the GAM memory.
// Serves learn (node write), inc (M read-modify-write) and recall (class scan).
// Optional feature macro: GAM_RR_ARB_EN selects round-robin arbitration;
// when it is undefined, arbitration is fixed priority learn > inc > recall.
module gam_mem_scheduler #(
  parameter int unsigned NUM_CLASSES = 8,
  parameter int unsigned NUM_NODES   = 16,
  parameter int unsigned VEC_W       = 32,
  localparam int unsigned CLS_W      = $clog2(NUM_CLASSES),
  localparam int unsigned NODE_W     = $clog2(NUM_NODES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lrn_req,
  input  logic [CLS_W-1:0]  lrn_class,
  input  logic [NODE_W-1:0] lrn_node,
  input  logic [3:0]        lrn_fields,
  input  logic [31:0]       lrn_Th,
  input  logic [31:0]       lrn_M,
  output logic              lrn_ack,
  input  logic              inc_req,
  input  logic [CLS_W-1:0]  inc_class,
  input  logic [NODE_W-1:0] inc_node,
  output logic              inc_ack,
  output logic [31:0]       inc_M,
  input  logic              rcl_req,
  input  logic [CLS_W-1:0]  rcl_class,
  output logic              rcl_valid,
  output logic [NODE_W-1:0] rcl_node,
  output logic [VEC_W-1:0]  rcl_W,
  output logic [31:0]       rcl_Th,
  output logic              rcl_done,
  output logic [31:0]       mem_class,
  output logic [31:0]       mem_node,
  output logic              mem_X_c,
  output logic              mem_C_c,
  output logic              mem_W_c,
  output logic              mem_T_c,
  output logic              mem_M_c,
  output logic              mem_rd_wr,
  output logic [31:0]       mem_Th,
  output logic [31:0]       mem_M,
  input  logic [31:0]       mem_Th_o,
  input  logic [31:0]       mem_M_o,
  input  logic [VEC_W-1:0]  mem_W_o
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_INC_RD, S_INC_WR, S_SCAN} state_e;
  typedef enum logic [1:0] {REQ_LRN, REQ_INC, REQ_RCL, REQ_NONE} req_e;
  typedef enum logic {READ = 1'b0, WRITE = 1'b1} rd_wr_e;

  state_e             state_q;
  logic [CLS_W-1:0]   mem_class_q;
  logic [NODE_W-1:0]  mem_node_q;
  logic               x_c_q, c_c_q, w_c_q, t_c_q, m_c_q;
  rd_wr_e             rd_wr_q;
  logic [31:0]        mem_Th_q, mem_M_q;
  logic               lrn_ack_q, inc_ack_q;
  logic               rcl_valid_q, rcl_done_q, scan_drain_q;
  logic [NODE_W-1:0]  rcl_node_q;
  logic [VEC_W-1:0]   rcl_W_q;
  logic [31:0]        rcl_Th_q;
  req_e               gnt_d;
  logic [31:0]        inc_sat_d;

`ifdef GAM_RR_ARB_EN
  req_e               ptr_q;
  logic [3:0]         req_vec;
  logic [2:0]         sum;
  logic [1:0]         idx;

  // Round-robin grant: scan requesters starting at the pointer position.
  always_comb begin
    gnt_d   = REQ_NONE;
    req_vec = {1'b0, rcl_req, inc_req, lrn_req};
    sum     = '0;
    idx     = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      sum = {1'b0, ptr_q} + {1'b0, k[1:0]};
      idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      if (gnt_d == REQ_NONE && req_vec[idx]) gnt_d = req_e'(idx);
    end
  end
`else
  // Fixed-priority grant: learn > inc > recall.
  always_comb begin
    gnt_d = REQ_NONE;
    if (lrn_req)      gnt_d = REQ_LRN;
    else if (inc_req) gnt_d = REQ_INC;
    else if (rcl_req) gnt_d = REQ_RCL;
  end
`endif

  // Saturating increment of the M value read during INC_RD.
  always_comb begin
    inc_sat_d = (mem_M_o >= 32'h7FFF_FFFF) ? 32'h7FFF_FFFF : mem_M_o + 32'd1;
  end

  // Sequencer FSM; every memory-side and requester-side output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mem_class_q  <= '0;
      mem_node_q   <= '0;
      x_c_q        <= 1'b0;
      c_c_q        <= 1'b0;
      w_c_q        <= 1'b0;
      t_c_q        <= 1'b0;
      m_c_q        <= 1'b0;
      rd_wr_q      <= READ;
      mem_Th_q     <= '0;
      mem_M_q      <= '0;
      lrn_ack_q    <= 1'b0;
      inc_ack_q    <= 1'b0;
      rcl_valid_q  <= 1'b0;
      rcl_done_q   <= 1'b0;
      scan_drain_q <= 1'b0;
      rcl_node_q   <= '0;
      rcl_W_q      <= '0;
      rcl_Th_q     <= '0;
`ifdef GAM_RR_ARB_EN
      ptr_q        <= REQ_LRN;
`endif
    end else begin
      lrn_ack_q   <= 1'b0;
      inc_ack_q   <= 1'b0;
      rcl_valid_q <= 1'b0;
      rcl_done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          {x_c_q, c_c_q, w_c_q, t_c_q, m_c_q} <= '0;
          rd_wr_q <= READ;
          case (gnt_d)
            REQ_LRN: begin
              state_q     <= S_WR;
              mem_class_q <= lrn_class;
              mem_node_q  <= lrn_node;
              c_c_q       <= 1'b1;
              {x_c_q, w_c_q, t_c_q, m_c_q} <= lrn_fields;
              rd_wr_q     <= WRITE;
              mem_Th_q    <= lrn_Th;
              mem_M_q     <= lrn_M;
              lrn_ack_q   <= 1'b1;
            end
            REQ_INC: begin
              state_q     <= S_INC_RD;
              mem_class_q <= inc_class;
              mem_node_q  <= inc_node;
              m_c_q       <= 1'b1;
            end
            REQ_RCL: begin
              state_q      <= S_SCAN;
              mem_class_q  <= rcl_class;
              mem_node_q   <= '0;
              w_c_q        <= 1'b1;
              t_c_q        <= 1'b1;
              scan_drain_q <= 1'b0;
            end
            default: ;
          endcase
`ifdef GAM_RR_ARB_EN
          case (gnt_d)
            REQ_LRN: ptr_q <= REQ_INC;
            REQ_INC: ptr_q <= REQ_RCL;
            REQ_RCL: ptr_q <= REQ_LRN;
            default: ;
          endcase
`endif
        end
        S_WR: begin
          {x_c_q, c_c_q, w_c_q, t_c_q, m_c_q} <= '0;
          rd_wr_q <= READ;
          state_q <= S_IDLE;
        end
        S_INC_RD: begin
          state_q   <= S_INC_WR;
          rd_wr_q   <= WRITE;
          mem_M_q   <= inc_sat_d;
          inc_ack_q <= 1'b1;
        end
        S_INC_WR: begin
          m_c_q   <= 1'b0;
          rd_wr_q <= READ;
          state_q <= S_IDLE;
        end
        S_SCAN: begin
          // An extra drain cycle keeps the FSM in SCAN while the last beat is
          // presented, so a still-held rcl_req is not re-granted.
          if (!scan_drain_q) begin
            rcl_valid_q <= 1'b1;
            rcl_node_q  <= mem_node_q;
            rcl_W_q     <= mem_W_o;
            rcl_Th_q    <= mem_Th_o;
            if (mem_node_q == NODE_W'(NUM_NODES - 1)) begin
              scan_drain_q <= 1'b1;
              rcl_done_q   <= 1'b1;
              w_c_q        <= 1'b0;
              t_c_q        <= 1'b0;
            end else begin
              mem_node_q <= mem_node_q + 1'b1;
            end
          end else begin
            scan_drain_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign lrn_ack   = lrn_ack_q;
  assign inc_ack   = inc_ack_q;
  assign inc_M     = mem_M_q;
  assign rcl_valid = rcl_valid_q;
  assign rcl_node  = rcl_node_q;
  assign rcl_W     = rcl_W_q;
  assign rcl_Th    = rcl_Th_q;
  assign rcl_done  = rcl_done_q;
  assign mem_class = 32'(mem_class_q);
  assign mem_node  = 32'(mem_node_q);
  assign mem_X_c   = x_c_q;
  assign mem_C_c   = c_c_q;
  assign mem_W_c   = w_c_q;
  assign mem_T_c   = t_c_q;
  assign mem_M_c   = m_c_q;
  assign mem_rd_wr = rd_wr_q;
  assign mem_Th    = mem_Th_q;
  assign mem_M     = mem_M_q;

  // Requesters must hold their request until acknowledged.
  a_lrn_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (lrn_req && !lrn_ack) |=> lrn_req);
  a_inc_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (inc_req && !inc_ack) |=> inc_req);
  a_rcl_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (rcl_req && !rcl_done) |=> rcl_req);

endmodule

// File: tb/tb_gam_mem_scheduler.sv
// Directed testbench for gam_mem_scheduler with a behavioural GAM memory model.
module tb_gam_mem_scheduler;
  localparam int CW = 3;
  localparam int NW = 4;
  localparam int NN = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lrn_req, inc_req, rcl_req;
  logic [CW-1:0] lrn_class, inc_class, rcl_class;
  logic [NW-1:0] lrn_node, inc_node, rcl_node;
  logic [3:0]  lrn_fields;
  logic [31:0] lrn_Th, lrn_M, lrn_W, inc_M, rcl_W, rcl_Th;
  logic        lrn_ack, inc_ack, rcl_valid, rcl_done;
  logic [31:0] mem_class, mem_node, mem_Th, mem_M, mem_Th_o, mem_M_o, mem_W_o;
  logic        mem_X_c, mem_C_c, mem_W_c, mem_T_c, mem_M_c, mem_rd_wr;

  logic [31:0] th_mem [8][NN];
  logic [31:0] m_mem  [8][NN];
  logic [31:0] w_mem  [8][NN];

  logic [NW-1:0] b_node [NN];
  logic [31:0]   b_th   [NN];
  logic [31:0]   b_w    [NN];

  int n_chk = 0;
  int n_pass = 0;

  gam_mem_scheduler #(.NUM_CLASSES(8), .NUM_NODES(16), .VEC_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .lrn_req(lrn_req), .lrn_class(lrn_class), .lrn_node(lrn_node),
    .lrn_fields(lrn_fields), .lrn_Th(lrn_Th), .lrn_M(lrn_M), .lrn_ack(lrn_ack),
    .inc_req(inc_req), .inc_class(inc_class), .inc_node(inc_node),
    .inc_ack(inc_ack), .inc_M(inc_M),
    .rcl_req(rcl_req), .rcl_class(rcl_class), .rcl_valid(rcl_valid),
    .rcl_node(rcl_node), .rcl_W(rcl_W), .rcl_Th(rcl_Th), .rcl_done(rcl_done),
    .mem_class(mem_class), .mem_node(mem_node),
    .mem_X_c(mem_X_c), .mem_C_c(mem_C_c), .mem_W_c(mem_W_c),
    .mem_T_c(mem_T_c), .mem_M_c(mem_M_c), .mem_rd_wr(mem_rd_wr),
    .mem_Th(mem_Th), .mem_M(mem_M),
    .mem_Th_o(mem_Th_o), .mem_M_o(mem_M_o), .mem_W_o(mem_W_o)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, field-enabled write on the falling edge.
  assign mem_Th_o = th_mem[mem_class[CW-1:0]][mem_node[NW-1:0]];
  assign mem_M_o  = m_mem[mem_class[CW-1:0]][mem_node[NW-1:0]];
  assign mem_W_o  = w_mem[mem_class[CW-1:0]][mem_node[NW-1:0]];

  always @(negedge clk) begin
    if (mem_rd_wr) begin
      if (mem_T_c) th_mem[mem_class[CW-1:0]][mem_node[NW-1:0]] <= mem_Th;
      if (mem_M_c) m_mem[mem_class[CW-1:0]][mem_node[NW-1:0]]  <= mem_M;
      if (mem_W_c) w_mem[mem_class[CW-1:0]][mem_node[NW-1:0]]  <= lrn_W;
    end
  end

  function automatic logic [31:0] pre_th(input int c, input int n);
    return 32'(1000 + c * 16 + n);
  endfunction

  function automatic logic [31:0] pre_w(input int c, input int n);
    return 32'hA500_0000 | 32'(c * 256 + n);
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic do_learn(input int c, input int n, input logic [3:0] f,
                          input logic [31:0] th, input logic [31:0] m,
                          input logic [31:0] w, output int lat);
    @(posedge clk); #1;
    lrn_class = 3'(c); lrn_node = 4'(n); lrn_fields = f;
    lrn_Th = th; lrn_M = m; lrn_W = w; lrn_req = 1'b1;
    lat = 0;
    do begin @(posedge clk); lat++; @(negedge clk); end while (!lrn_ack && lat < 40);
    @(posedge clk); #1 lrn_req = 1'b0;
  endtask

  task automatic do_inc(input int c, input int n, output int lat, output logic [31:0] mv);
    @(posedge clk); #1;
    inc_class = 3'(c); inc_node = 4'(n); inc_req = 1'b1;
    lat = 0;
    do begin @(posedge clk); lat++; @(negedge clk); end while (!inc_ack && lat < 40);
    mv = inc_M;
    @(posedge clk); #1 inc_req = 1'b0;
  endtask

  task automatic do_scan(input int c, output int nb, output int done_at, output int gap);
    int cyc;
    @(posedge clk); #1;
    rcl_class = 3'(c); rcl_req = 1'b1;
    cyc = 0; nb = 0; done_at = -1; gap = 0;
    do begin
      @(posedge clk); cyc++; @(negedge clk);
      if (rcl_valid) begin
        if (nb < NN) begin b_node[nb] = rcl_node; b_th[nb] = rcl_Th; b_w[nb] = rcl_W; end
        if (rcl_done) done_at = nb;
        nb++;
      end else if (nb > 0) gap = 1;
    end while (!rcl_done && cyc < 100);
    @(posedge clk); #1 rcl_req = 1'b0;
  endtask

  // Concurrent requesters; ordv records grant order as digits 1=learn 2=inc 3=recall.
  task automatic multi(input bit ul, input bit ui, input bit ur, input int l_tgt,
                       output int ordv, output int l_before_r, output bit fin);
    int  l_acks = 0;
    int  cyc = 0;
    bit  l_d = !ul, i_d = !ui, r_d = !ur, r_seen = 0;
    bit  dl, di, dr;
    ordv = 0; l_before_r = -1;
    @(posedge clk); #1;
    lrn_req = ul; inc_req = ui; rcl_req = ur;
    while (!(l_d && i_d && r_d) && cyc < 400) begin
      @(negedge clk);
      dl = 0; di = 0; dr = 0;
      if (lrn_ack) begin
        l_acks++;
        if (l_acks == 1) ordv = ordv * 10 + 1;
        if (l_acks == l_tgt) dl = 1;
      end
      if (inc_ack) begin ordv = ordv * 10 + 2; di = 1; end
      if (rcl_valid && !r_seen) begin r_seen = 1; ordv = ordv * 10 + 3; l_before_r = l_acks; end
      if (rcl_done) dr = 1;
      @(posedge clk); #1;
      if (dl) begin lrn_req = 1'b0; l_d = 1; end
      if (di) begin inc_req = 1'b0; i_d = 1; end
      if (dr) begin rcl_req = 1'b0; r_d = 1; end
      cyc++;
    end
    fin = l_d && i_d && r_d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, nb, done_at, gap, errs, ordv, lbr;
    bit fin;
    logic [31:0] mv;

    for (int c = 0; c < 8; c++)
      for (int n = 0; n < NN; n++) begin
        th_mem[c][n] = pre_th(c, n);
        w_mem[c][n]  = pre_w(c, n);
        m_mem[c][n]  = '0;
      end
    rst_n = 1'b0;
    lrn_req = 0; inc_req = 0; rcl_req = 0;
    lrn_class = '0; lrn_node = '0; lrn_fields = '0; lrn_Th = '0; lrn_M = '0; lrn_W = '0;
    inc_class = '0; inc_node = '0; rcl_class = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_ctl", {mem_X_c, mem_C_c, mem_W_c, mem_T_c, mem_M_c, mem_rd_wr,
                           lrn_ack, inc_ack, rcl_valid, rcl_done}, '0);
    check_eq("reset_bus", {mem_class, mem_node, mem_M}, '0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Reset asserted inside INC_WR, before the falling-edge write.
    m_mem[2][4] = 32'd20;
    @(posedge clk); #1;
    inc_class = 3'd2; inc_node = 4'd4; inc_req = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    check_eq("t1_in_inc_wr", {inc_ack, mem_M_c, mem_rd_wr, mem_M}, {3'b111, 32'd21});
    #1 rst_n = 1'b0;
    #1 inc_req = 1'b0;
    @(negedge clk); #1;
    check_eq("t1_rst_ctl", {mem_X_c, mem_C_c, mem_W_c, mem_T_c, mem_M_c, mem_rd_wr,
                            lrn_ack, inc_ack, rcl_valid, rcl_done}, '0);
    check_eq("t1_rst_bus", {mem_class, mem_M, inc_M}, '0);
    check_eq("t1_m_kept", m_mem[2][4], 32'd20);
    @(posedge clk); #1 rst_n = 1'b1;
    do_learn(7, 7, 4'b0000, 32'd0, 32'd0, 32'd0, lat);
    check_eq("t1_idle_after_rst", lat, 1);

    // Increment and saturation.
    m_mem[4][9] = 32'd7;
    do_inc(4, 9, lat, mv);
    check_eq("t3_inc_lat", lat, 2);
    check_eq("t3_inc_M", mv, 32'd8);
    check_eq("t3_mem_M", m_mem[4][9], 32'd8);
    m_mem[4][10] = 32'h7FFF_FFFF;
    do_inc(4, 10, lat, mv);
    check_eq("t3_sat_M", mv, 32'h7FFF_FFFF);
    check_eq("t3_sat_mem", m_mem[4][10], 32'h7FFF_FFFF);
    m_mem[4][11] = 32'h7FFF_FFFE;
    do_inc(4, 11, lat, mv);
    check_eq("t3_to_max", mv, 32'h7FFF_FFFF);

    // Learn with no fields enabled still acknowledges and writes nothing.
    m_mem[6][2] = 32'd66;
    do_learn(6, 2, 4'b0000, 32'd1, 32'd2, 32'd3, lat);
    check_eq("t6_lat", lat, 1);
    check_eq("t6_unchanged", {th_mem[6][2], m_mem[6][2], w_mem[6][2]},
             {pre_th(6, 2), 32'd66, pre_w(6, 2)});

    // Full learn then scan of the same class.
    do_learn(3, 5, 4'b1111, 32'd10, 32'd2, 32'h1234_5678, lat);
    check_eq("t2_lat", lat, 1);
    check_eq("t2_mem_M", m_mem[3][5], 32'd2);
    do_scan(3, nb, done_at, gap);
    check_eq("t2_beats", nb, NN);
    check_eq("t2_node5", {28'd0, b_node[5], b_th[5], b_w[5]}, {32'd5, 32'd10, 32'h1234_5678});
    check_eq("t2_node4", b_th[4], pre_th(3, 4));

    // Full scan of class 1 against preload.
    do_scan(1, nb, done_at, gap);
    check_eq("t4_beats", nb, NN);
    check_eq("t4_done_at", done_at, NN - 1);
    check_eq("t4_gap", gap, 0);
    errs = 0;
    for (int i = 0; i < NN; i++)
      if (b_node[i] !== 4'(i) || b_th[i] !== pre_th(1, i) || b_w[i] !== pre_w(1, i)) errs++;
    check_eq("t4_data", errs, 0);

    // Simultaneous requests from all three.
    lrn_fields = 4'b0000; inc_class = 3'd0; inc_node = 4'd0; rcl_class = 3'd2;
    multi(1, 1, 1, 1, ordv, lbr, fin);
    check_eq("t5_finish", fin, 1);
    check_eq("t5_order", ordv, 123);

    // Learn held for two operations against a waiting recall.
    multi(1, 0, 1, 2, ordv, lbr, fin);
    check_eq("t5_cont_finish", fin, 1);
`ifdef GAM_RR_ARB_EN
    check_eq("t5_rr_rotation", lbr, 1);
`else
    check_eq("t5_fixed_prio", lbr, 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
